// File: rtl/seq_pkg.sv
// Shared definitions for the microprogrammed sequencer and the datapath it drives:
// sequencing ops, FSM states, and microinstruction / control-word field positions.
package seq_pkg;

    typedef enum logic [2:0] {
        SEQ_NEXT = 3'd0,
        SEQ_JMP  = 3'd1,
        SEQ_BZ   = 3'd2,
        SEQ_BN   = 3'd3,
        SEQ_BC   = 3'd4,
        SEQ_BV   = 3'd5,
        SEQ_BB   = 3'd6,
        SEQ_HALT = 3'd7
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    // Control-word fields as seen by the datapath
    localparam int DA_HI  = 15;
    localparam int DA_LO  = 13;
    localparam int AA_HI  = 12;
    localparam int AA_LO  = 10;
    localparam int BA_HI  = 9;
    localparam int BA_LO  = 7;
    localparam int MB_BIT = 6;
    localparam int FS_HI  = 5;
    localparam int FS_LO  = 2;
    localparam int MD_BIT = 1;
    localparam int RW_BIT = 0;

    // Microinstruction layout
    localparam int UI_W   = 24;
    localparam int OP_HI  = 23;
    localparam int OP_LO  = 21;
    localparam int TGT_LO = 16;

    function automatic logic branch_taken(input seq_op_e op, input logic v, input logic c,
                                          input logic n, input logic z, input logic tb);
        case (op)
            SEQ_BZ:  return z;
            SEQ_BN:  return n;
            SEQ_BC:  return c;
            SEQ_BV:  return v;
            SEQ_BB:  return tb;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Host/datapath-facing signal bundle of the micro sequencer.
interface micro_sequencer_if #(
    parameter int AW   = 5,
    parameter int CW_W = 16
);
    logic            start;
    logic            ld_en;
    logic [AW-1:0]   ld_addr;
    logic [23:0]     ld_data;
    logic            V;
    logic            C;
    logic            N;
    logic            Z;
    logic            test_bit;
    logic [CW_W-1:0] ctrl_word;
    logic [AW-1:0]   pc;
    logic [1:0]      state;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, ld_en, ld_addr, ld_data, V, C, N, Z, test_bit,
        input  ctrl_word, pc, state, busy, done, err
    );

    modport slave (
        input  start, ld_en, ld_addr, ld_data, V, C, N, Z, test_bit,
        output ctrl_word, pc, state, busy, done, err
    );
endinterface

// File: rtl/micro_sequencer_rom.sv
// Loadable microprogram store: synchronous write, combinational read.
module useq_rom #(
    parameter int AW = 5,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed control unit: fetches from a loadable store, issues one registered
// control word per RUN cycle and branches on datapath flags or an external test bit.
module micro_sequencer
    import seq_pkg::*;
#(
    parameter int AW         = 5,
    parameter int CW_W       = 16,
    parameter int MAX_CYCLES = 255
) (
    input logic              Clk,
    input logic              Rst,
    micro_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    seq_state_e      state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [CW_W-1:0] cw_q, cw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [UI_W-1:0] cur;
    seq_op_e         op;
    logic [AW-1:0]   tgt;
    logic [AW-1:0]   pc_inc;
    logic            rom_we;

    // Store writes are only honoured while idle so a running program can't be altered
    assign rom_we = (state_q == ST_IDLE) && bus.ld_en && !Rst;

    useq_rom #(
        .AW(AW),
        .DW(UI_W)
    ) u_rom (
        .clk  (Clk),
        .we   (rom_we),
        .waddr(bus.ld_addr),
        .wdata(bus.ld_data),
        .raddr(pc_q),
        .rdata(cur)
    );

    assign op     = seq_op_e'(cur[OP_HI:OP_LO]);
    assign tgt    = cur[TGT_LO +: AW];
    assign pc_inc = pc_q + 1'b1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cw_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cw_q    <= cw_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cw_d    = '0;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                // Watchdog abort replaces the pending instruction entirely
                if (cnt_q == CNT_W'(MAX_CYCLES)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cw_d  = cur[CW_W-1:0];
                    cnt_d = cnt_q + 1'b1;
                    case (op)
                        SEQ_NEXT: pc_d = pc_inc;
                        SEQ_JMP:  pc_d = tgt;
                        SEQ_HALT: state_d = ST_DONE;
                        default:  pc_d = branch_taken(op, bus.V, bus.C, bus.N, bus.Z, bus.test_bit)
                                         ? tgt : pc_inc;
                    endcase
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ctrl_word = cw_q;
    assign bus.pc        = pc_q;
    assign bus.state     = state_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: expected pc/control-word streams are queued
// per program and popped as the sequencer executes.
module tb_micro_sequencer;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [4:0]  exp_pc [$];
    logic [15:0] exp_cw [$];

    logic [3:0] flag_en = '0;   // {V,C,N,Z}
    logic       bb_mode = 1'b0;
    int         bb_hits;

    micro_sequencer_if #(.AW(5), .CW_W(16)) bus ();

    micro_sequencer #(
        .AW        (5),
        .CW_W      (16),
        .MAX_CYCLES(8)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: enabled flags assert whenever a non-zero control word is applied
    assign bus.Z = flag_en[0] & (|bus.ctrl_word);
    assign bus.N = flag_en[1] & (|bus.ctrl_word);
    assign bus.C = flag_en[2] & (|bus.ctrl_word);
    assign bus.V = flag_en[3] & (|bus.ctrl_word);

    // test_bit stays high for the first four BB evaluations at address 2
    always @(posedge clk) begin
        if (rst || !bb_mode) bb_hits <= 0;
        else if (bus.state == 2'b01 && bus.pc == 5'd2) bb_hits <= bb_hits + 1;
    end
    assign bus.test_bit = bb_mode && (bb_hits < 4);

    function automatic logic [23:0] ui(input logic [2:0] op, input logic [4:0] t, input logic [15:0] cw);
        return {op, t, cw};
    endfunction

    task automatic load(input logic [4:0] a, input logic [23:0] d);
        @(negedge clk);
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        @(negedge clk);
        bus.ld_en = 1'b0;
    endtask

    task automatic run_check(input string name, input int budget, input bit exp_err,
                             input bit with_ld, input logic [4:0] la, input logic [23:0] ld);
        int  n;
        bit  prev_run;
        logic [4:0]  ep;
        logic [15:0] ec;
        @(negedge clk);
        bus.start = 1'b1;
        if (with_ld) begin bus.ld_en = 1'b1; bus.ld_addr = la; bus.ld_data = ld; end
        @(negedge clk);
        bus.start = 1'b0; bus.ld_en = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.ctrl_word !== 16'h0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL %s launch busy=%b cw=%h err=%b exp busy=1 cw=0000 err=0", name, bus.busy, bus.ctrl_word, bus.err);
        end
        n = 0;
        while (n < budget) begin
            if (bus.state == 2'b10) begin
                checks++;
                if (bus.done !== 1'b1 || bus.err !== exp_err) begin
                    failures++;
                    $display("FAIL %s done_flags done=%b err=%b exp done=1 err=%b", name, bus.done, bus.err, exp_err);
                end
                break;
            end
            if (bus.state == 2'b01) begin
                ep = (exp_pc.size() > 0) ? exp_pc.pop_front() : 5'bx;
                checks++;
                if (bus.pc !== ep) begin
                    failures++;
                    $display("FAIL %s pc got=%0d exp=%0d", name, bus.pc, ep);
                end
            end
            prev_run = (bus.state == 2'b01);
            @(negedge clk);
            n++;
            if (prev_run) begin
                ec = (exp_cw.size() > 0) ? exp_cw.pop_front() : 16'hx;
                checks++;
                if (bus.ctrl_word !== ec) begin
                    failures++;
                    $display("FAIL %s ctrl_word got=%h exp=%h", name, bus.ctrl_word, ec);
                end
            end
        end
        checks++;
        if (n >= budget || exp_pc.size() != 0 || exp_cw.size() != 0) begin
            failures++;
            $display("FAIL %s completion cycles=%0d left_pc=%0d left_cw=%0d exp all drained before %0d",
                     name, n, exp_pc.size(), exp_cw.size(), budget);
        end
        exp_pc.delete(); exp_cw.delete();
        @(negedge clk);
        checks++;
        if (bus.state !== 2'b00 || bus.ctrl_word !== 16'h0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL %s return_idle state=%b cw=%h done=%b exp 00/0000/0", name, bus.state, bus.ctrl_word, bus.done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.state !== 2'b00 || bus.pc !== 5'd0 || bus.ctrl_word !== 16'h0 ||
            bus.done !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset state=%b pc=%0d cw=%h done=%b err=%b busy=%b exp all zero",
                     bus.state, bus.pc, bus.ctrl_word, bus.done, bus.err, bus.busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_halt();
        load(5'd0, ui(SEQ_NEXT, 5'd0, 16'h2003));
        load(5'd1, ui(SEQ_HALT, 5'd0, 16'h8515));
        exp_pc = '{5'd0, 5'd1};
        exp_cw = '{16'h2003, 16'h8515};
        run_check("halt", 20, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_branches();
        load(5'd0, ui(SEQ_NEXT, 5'd0, 16'h0104));
        load(5'd2, ui(SEQ_HALT, 5'd0, 16'h0400));
        load(5'd5, ui(SEQ_HALT, 5'd0, 16'h0300));
        for (int k = 0; k < 4; k++) begin
            load(5'd1, ui(3'(2 + k), 5'd5, 16'h0200));
            flag_en = 4'(1 << k);
            exp_pc = '{5'd0, 5'd1, 5'd5};
            exp_cw = '{16'h0104, 16'h0200, 16'h0300};
            run_check("branch_taken", 20, 1'b0, 1'b0, '0, '0);
            flag_en = ~4'(1 << k);
            exp_pc = '{5'd0, 5'd1, 5'd2};
            exp_cw = '{16'h0104, 16'h0200, 16'h0400};
            run_check("branch_not_taken", 20, 1'b0, 1'b0, '0, '0);
        end
        flag_en = '0;
    endtask

    task automatic test_bb_loop();
        load(5'd0, ui(SEQ_NEXT, 5'd0, 16'h00A0));
        load(5'd1, ui(SEQ_NEXT, 5'd0, 16'h00A1));
        load(5'd2, ui(SEQ_BB,   5'd2, 16'h00A2));
        load(5'd3, ui(SEQ_HALT, 5'd0, 16'h00A3));
        bb_mode = 1'b1;
        exp_pc = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd3};
        exp_cw = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A2, 16'h00A2, 16'h00A2, 16'h00A2, 16'h00A3};
        run_check("bb_loop", 20, 1'b0, 1'b0, '0, '0);
        bb_mode = 1'b0;
    endtask

    task automatic test_watchdog();
        load(5'd0, ui(SEQ_JMP, 5'd0, 16'h0C0C));
        for (int i = 0; i < 9; i++) exp_pc.push_back(5'd0);
        for (int i = 0; i < 8; i++) exp_cw.push_back(16'h0C0C);
        exp_cw.push_back(16'h0000);
        run_check("watchdog", 20, 1'b1, 1'b0, '0, '0);
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL watchdog_err_hold err=%b exp=1", bus.err);
        end
    endtask

    task automatic test_ignored_inputs();
        for (int i = 0; i < 4; i++) load(5'(i), ui(SEQ_NEXT, 5'd0, 16'hB000 + 16'(i)));
        load(5'd4, ui(SEQ_HALT, 5'd0, 16'hB004));
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin
                exp_pc.push_back(5'(i));
                exp_cw.push_back(16'hB000 + 16'(i));
            end
            fork
                run_check("ignored_inputs", 20, 1'b0, 1'b0, '0, '0);
                if (r == 0) begin
                    repeat (4) @(negedge clk);
                    bus.ld_en = 1'b1; bus.ld_addr = 5'd3; bus.ld_data = ui(SEQ_HALT, 5'd0, 16'hDEAD);
                    bus.start = 1'b1;
                    @(negedge clk);
                    bus.ld_en = 1'b0; bus.start = 1'b0;
                end
            join
        end
    endtask

    task automatic test_reset_mid_run();
        bit hit = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy === 1'b1 && bus.pc === 5'd3) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reset_mid_run reach_pc3 got=%b exp=1", hit);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.state !== 2'b00 || bus.pc !== 5'd0 || bus.ctrl_word !== 16'h0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_run state=%b pc=%0d cw=%h busy=%b exp 00/0/0000/0",
                     bus.state, bus.pc, bus.ctrl_word, bus.busy);
        end
        for (int i = 0; i < 5; i++) begin
            exp_pc.push_back(5'(i));
            exp_cw.push_back(16'hB000 + 16'(i));
        end
        run_check("rerun_after_reset", 20, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_start_with_load();
        exp_pc = '{5'd0};
        exp_cw = '{16'h5A5A};
        run_check("start_with_load", 20, 1'b0, 1'b1, 5'd0, ui(SEQ_HALT, 5'd0, 16'h5A5A));
    endtask

    initial begin
        bus.start = 1'b0; bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        test_reset();
        test_halt();
        test_branches();
        test_bb_loop();
        test_watchdog();
        test_ignored_inputs();
        test_reset_mid_run();
        test_start_with_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t exp completion earlier", $time);
        $fatal(1, "timeout");
    end
endmodule
